// File: rtl/vram_fill_pkg.sv
// Shared definitions for the VRAM fill engine: register offsets, CTRL/STATUS
// bit positions and the engine state encoding.
package vram_fill_pkg;

   localparam logic [2:0] REG_DST_LO   = 3'd0;
   localparam logic [2:0] REG_DST_HI   = 3'd1;
   localparam logic [2:0] REG_LEN_LO   = 3'd2;
   localparam logic [2:0] REG_LEN_HI   = 3'd3;
   localparam logic [2:0] REG_FILL_CHR = 3'd4;
   localparam logic [2:0] REG_FILL_COL = 3'd5;
   localparam logic [2:0] REG_CTRL     = 3'd6;
   localparam logic [2:0] REG_STATUS   = 3'd7;

   localparam int CTRL_START   = 0;
   localparam int CTRL_TGT_CHR = 1;
   localparam int CTRL_TGT_COL = 2;
   localparam int CTRL_ABORT   = 7;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fill_state_t;

endpackage

// File: rtl/vram_fill_ctrl.sv
// Fill engine and port-A arbiter for chram/colram. The CPU always owns port A
// when it touches VRAM; the engine only uses otherwise idle cycles.
module vram_fill_ctrl #(
   parameter int ADDR_W = 11,
   parameter int LEN_W  = 12
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              reg_cs,
   input  logic              reg_wr,
   input  logic [2:0]        reg_addr,
   input  logic [7:0]        reg_din,
   output logic [7:0]        reg_dout,
   input  logic              cpu_vram_cs,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_dout,
   input  logic              cpu_chram_wr,
   input  logic              cpu_colram_wr,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              chram_we,
   output logic              colram_we,
   output logic [7:0]        chram_wdata,
   output logic [7:0]        colram_wdata,
   output logic              busy,
   output logic              done_pulse
);

   import vram_fill_pkg::*;

   localparam logic [LEN_W-1:0] MAX_RUN = LEN_W'(2 ** ADDR_W);

   fill_state_t       state;
   fill_state_t       state_next;

   logic [ADDR_W-1:0] dst_reg;
   logic [LEN_W-1:0]  len_reg;
   logic [7:0]        fill_chr;
   logic [7:0]        fill_col;

   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  rem_cnt;
   logic              tgt_chr;
   logic              tgt_col;
   logic              done_flag;

   logic              reg_write;
   logic              ctrl_write;
   logic              start_req;
   logic              abort_req;
   logic              status_read;

   logic              load_run;
   logic              zero_start;
   logic              engine_active;
   logic              last_write;
   logic              abort_run;

   assign reg_write   = reg_cs && reg_wr;
   assign ctrl_write  = reg_write && (reg_addr == REG_CTRL);
   assign abort_req   = ctrl_write && reg_din[CTRL_ABORT];
   assign start_req   = ctrl_write && reg_din[CTRL_START] && !reg_din[CTRL_ABORT];
   assign status_read = reg_cs && !reg_wr && (reg_addr == REG_STATUS);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the port-A mux; the engine only drives the port in RUN
   // on cycles where the CPU is not addressing VRAM.
   always_comb begin
      state_next    = state;
      load_run      = 1'b0;
      zero_start    = 1'b0;
      engine_active = 1'b0;
      last_write    = 1'b0;
      abort_run     = 1'b0;
      busy          = (state == ST_RUN);
      vram_addr     = cpu_addr;
      chram_we      = cpu_chram_wr;
      colram_we     = cpu_colram_wr;
      chram_wdata   = cpu_dout;
      colram_wdata  = cpu_dout;

      case (state)
         ST_IDLE: begin
            if (start_req) begin
               if (len_reg != '0) begin
                  load_run   = 1'b1;
                  state_next = ST_RUN;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         ST_RUN: begin
            engine_active = !cpu_vram_cs;
            if (abort_req) begin
               abort_run  = 1'b1;
               state_next = ST_IDLE;
            end else if (engine_active && (rem_cnt == LEN_W'(1))) begin
               last_write = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (engine_active) begin
         vram_addr    = cur_addr;
         chram_we     = tgt_chr;
         colram_we    = tgt_col;
         chram_wdata  = fill_chr;
         colram_wdata = fill_col;
      end
   end

   // Programming registers are frozen during a run, so the fill bytes seen at
   // start stay constant until the run ends.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dst_reg  <= '0;
         len_reg  <= '0;
         fill_chr <= '0;
         fill_col <= '0;
      end else if (reg_write && (state == ST_IDLE)) begin
         case (reg_addr)
            REG_DST_LO:   dst_reg[7:0]        <= reg_din;
            REG_DST_HI:   dst_reg[ADDR_W-1:8] <= reg_din[ADDR_W-9:0];
            REG_LEN_LO:   len_reg[7:0]        <= reg_din;
            REG_LEN_HI:   len_reg[LEN_W-1:8]  <= reg_din[LEN_W-9:0];
            REG_FILL_CHR: fill_chr            <= reg_din;
            REG_FILL_COL: fill_col            <= reg_din;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cur_addr <= '0;
         rem_cnt  <= '0;
         tgt_chr  <= 1'b0;
         tgt_col  <= 1'b0;
      end else if (load_run) begin
         cur_addr <= dst_reg;
         rem_cnt  <= (len_reg > MAX_RUN) ? MAX_RUN : len_reg;
         tgt_chr  <= reg_din[CTRL_TGT_CHR];
         tgt_col  <= reg_din[CTRL_TGT_COL];
      end else if (engine_active) begin
         cur_addr <= cur_addr + ADDR_W'(1);
         rem_cnt  <= rem_cnt - LEN_W'(1);
      end
   end

   // A completion in the same cycle as a STATUS read wins, so it is never lost.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         done_flag  <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= zero_start || last_write || abort_run;
         if (zero_start || last_write || abort_run) begin
            done_flag <= 1'b1;
         end else if (load_run || status_read) begin
            done_flag <= 1'b0;
         end
      end
   end

   always_comb begin
      reg_dout = '0;
      case (reg_addr)
         REG_DST_LO:   reg_dout = dst_reg[7:0];
         REG_DST_HI:   reg_dout = 8'(dst_reg[ADDR_W-1:8]);
         REG_LEN_LO:   reg_dout = len_reg[7:0];
         REG_LEN_HI:   reg_dout = 8'(len_reg[LEN_W-1:8]);
         REG_FILL_CHR: reg_dout = fill_chr;
         REG_FILL_COL: reg_dout = fill_col;
         REG_STATUS: begin
            reg_dout[STAT_BUSY] = busy;
            reg_dout[STAT_DONE] = done_flag;
         end
         default:      reg_dout = '0;
      endcase
   end

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Bench for vram_fill_ctrl: a queue-of-addresses model checked every cycle,
// plus hand-computed run timelines for the directed scenarios.
module tb_vram_fill_ctrl;
   import vram_fill_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        reg_cs;
   logic        reg_wr;
   logic [2:0]  reg_addr;
   logic [7:0]  reg_din;
   logic [7:0]  reg_dout;
   logic        cpu_vram_cs;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_chram_wr;
   logic        cpu_colram_wr;
   logic [10:0] vram_addr;
   logic        chram_we;
   logic        colram_we;
   logic [7:0]  chram_wdata;
   logic [7:0]  colram_wdata;
   logic        busy;
   logic        done_pulse;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;

   logic [7:0] m_reg [6];
   bit         m_busy, m_done, m_pulse, m_tc, m_to;
   logic [7:0] m_fc, m_fo;
   int         exp_q[$];

   int wr_cyc[$], wr_adr[$], wr_we[$], pulse_cyc[$];
   int exp_off[8], exp_adr[8], exp_we[8];

   bit         eng, busy_before, pulse_n;
   int         len_v, dst_v;
   logic [7:0] rd_v;

   vram_fill_ctrl #(.ADDR_W(11), .LEN_W(12)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout),
      .cpu_vram_cs(cpu_vram_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .cpu_chram_wr(cpu_chram_wr), .cpu_colram_wr(cpu_colram_wr),
      .vram_addr(vram_addr), .chram_we(chram_we), .colram_we(colram_we),
      .chram_wdata(chram_wdata), .colram_wdata(colram_wdata),
      .busy(busy), .done_pulse(done_pulse)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
      m_busy = 0; m_done = 0; m_pulse = 0; m_tc = 0; m_to = 0;
      m_fc = 8'h00; m_fo = 8'h00;
      exp_q.delete();
   endtask

   function automatic logic [7:0] regMask(input int a);
      case (a)
         1:       return 8'h07;
         3:       return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] modelRead(input logic [2:0] a);
      if (a <= 3'd5) return m_reg[a];
      if (a == 3'd7) return {6'b0, m_done, m_busy};
      return 8'h00;
   endfunction

   // Model: a run is a queue of pending addresses; each free cycle pops one.
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         modelReset();
      end else begin
         eng = m_busy && !cpu_vram_cs && (exp_q.size() > 0);
         checkOutput("vram_addr", vram_addr, eng ? 11'(exp_q[0]) : cpu_addr);
         checkOutput("chram_we", chram_we, eng ? m_tc : cpu_chram_wr);
         checkOutput("colram_we", colram_we, eng ? m_to : cpu_colram_wr);
         checkOutput("chram_wdata", chram_wdata, eng ? m_fc : cpu_dout);
         checkOutput("colram_wdata", colram_wdata, eng ? m_fo : cpu_dout);
         checkOutput("busy", busy, m_busy);
         checkOutput("done_pulse", done_pulse, m_pulse);
         checkOutput("reg_dout", reg_dout, modelRead(reg_addr));

         if ((chram_we || colram_we) && !cpu_vram_cs) begin
            wr_cyc.push_back(cyc);
            wr_adr.push_back(int'(vram_addr));
            wr_we.push_back(int'({chram_we, colram_we}));
         end
         if (done_pulse) pulse_cyc.push_back(cyc);

         busy_before = m_busy;
         pulse_n = 0;
         if (reg_cs && !reg_wr && reg_addr == 3'd7) m_done = 0;
         if (eng) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               m_busy = 0; m_done = 1; pulse_n = 1;
            end
         end
         if (reg_cs && reg_wr) begin
            if (reg_addr <= 3'd5) begin
               if (!busy_before) m_reg[reg_addr] = reg_din & regMask(int'(reg_addr));
            end else if (reg_addr == 3'd6) begin
               if (reg_din[7]) begin
                  if (busy_before) begin
                     exp_q.delete(); m_busy = 0; m_done = 1; pulse_n = 1;
                  end
               end else if (reg_din[0] && !busy_before) begin
                  len_v = int'(m_reg[3]) * 256 + int'(m_reg[2]);
                  dst_v = int'(m_reg[1]) * 256 + int'(m_reg[0]);
                  if (len_v == 0) begin
                     m_done = 1; pulse_n = 1;
                  end else begin
                     m_done = 0;
                     if (len_v > 2048) len_v = 2048;
                     for (int i = 0; i < len_v; i++) exp_q.push_back((dst_v + i) % 2048);
                     m_busy = 1; m_tc = reg_din[1]; m_to = reg_din[2];
                     m_fc = m_reg[4]; m_fo = m_reg[5];
                  end
               end
            end
         end
         m_pulse = pulse_n;
      end
   end

   task automatic applyStimulus(input logic cs, input logic wr, input logic [2:0] addr,
                                input logic [7:0] din, input logic vcs);
      @(posedge clk_sys);
      #1;
      reg_cs = cs; reg_wr = wr; reg_addr = addr; reg_din = din; cpu_vram_cs = vcs;
      if (vcs) begin
         cpu_addr = 11'h555; cpu_dout = 8'hC3; cpu_chram_wr = 1'b1; cpu_colram_wr = 1'b0;
      end else begin
         cpu_addr = 11'h2AA; cpu_dout = 8'h3C; cpu_chram_wr = 1'b0; cpu_colram_wr = 1'b0;
      end
   endtask

   task automatic regWrite(input logic [2:0] a, input logic [7:0] d);
      applyStimulus(1'b1, 1'b1, a, d, 1'b0);
   endtask

   task automatic regRead(input logic [2:0] a, output logic [7:0] d);
      applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b0);
      #2;
      d = reg_dout;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
   endtask

   task automatic clearLogs();
      wr_cyc.delete(); wr_adr.delete(); wr_we.delete(); pulse_cyc.delete();
   endtask

   task automatic checkRun(input string name, input int n0, input int count, input int pulse_off);
      checkOutput({name, "_writes"}, wr_cyc.size(), count);
      for (int i = 0; i < count && i < wr_cyc.size(); i++) begin
         checkOutput({name, "_wr_cyc"}, wr_cyc[i], n0 + exp_off[i]);
         checkOutput({name, "_wr_addr"}, wr_adr[i], exp_adr[i]);
         checkOutput({name, "_wr_we"}, wr_we[i], exp_we[i]);
      end
      checkOutput({name, "_pulses"}, pulse_cyc.size(), 1);
      if (pulse_cyc.size() > 0) checkOutput({name, "_pulse_cyc"}, pulse_cyc[0], n0 + pulse_off);
   endtask

   initial begin
      int n0;
      int k;
      reset_n = 1'b0;
      reg_cs = 0; reg_wr = 0; reg_addr = 0; reg_din = 0;
      cpu_vram_cs = 0; cpu_addr = 11'h2AA; cpu_dout = 8'h3C; cpu_chram_wr = 0; cpu_colram_wr = 0;
      modelReset();
      repeat (3) @(posedge clk_sys);
      #1 reset_n = 1'b1;

      regRead(REG_STATUS, rd_v);
      checkOutput("reset_status", rd_v, 8'h00);

      $display("[TB] basic chram fill");
      regWrite(REG_DST_LO, 8'h10); regWrite(REG_DST_HI, 8'h00);
      regWrite(REG_LEN_LO, 8'h04); regWrite(REG_LEN_HI, 8'h00);
      regWrite(REG_FILL_CHR, 8'h41); regWrite(REG_FILL_COL, 8'hA5);
      clearLogs();
      regWrite(REG_CTRL, 8'h03); n0 = cyc;
      idleCycles(7);
      exp_off = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_adr = '{'h010, 'h011, 'h012, 'h013, 0, 0, 0, 0};
      exp_we  = '{2, 2, 2, 2, 0, 0, 0, 0};
      checkRun("basic", n0, 4, 5);
      regRead(REG_STATUS, rd_v); checkOutput("basic_status_done", rd_v, 8'h02);
      regRead(REG_STATUS, rd_v); checkOutput("basic_status_clr", rd_v, 8'h00);

      $display("[TB] CPU priority");
      clearLogs();
      regWrite(REG_CTRL, 8'h03); n0 = cyc;
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
      idleCycles(6);
      exp_off = '{1, 4, 5, 6, 0, 0, 0, 0};
      checkRun("prio", n0, 4, 7);

      $display("[TB] wrap with both targets");
      regWrite(REG_DST_LO, 8'hFE); regWrite(REG_DST_HI, 8'h07);
      clearLogs();
      regWrite(REG_CTRL, 8'h07); n0 = cyc;
      idleCycles(7);
      exp_off = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_adr = '{'h7FE, 'h7FF, 'h000, 'h001, 0, 0, 0, 0};
      exp_we  = '{3, 3, 3, 3, 0, 0, 0, 0};
      checkRun("wrap", n0, 4, 5);

      $display("[TB] zero length");
      regWrite(REG_LEN_LO, 8'h00);
      clearLogs();
      regWrite(REG_CTRL, 8'h03); n0 = cyc;
      idleCycles(3);
      checkRun("len0", n0, 0, 1);
      regRead(REG_STATUS, rd_v); checkOutput("len0_status", rd_v, 8'h02);

      $display("[TB] no target and idle abort");
      regWrite(REG_LEN_LO, 8'h03);
      clearLogs();
      regWrite(REG_CTRL, 8'h01); n0 = cyc;
      idleCycles(6);
      checkRun("notgt", n0, 0, 4);
      clearLogs();
      regWrite(REG_CTRL, 8'h80);
      regWrite(REG_CTRL, 8'h81);
      idleCycles(3);
      checkOutput("idle_abort_pulses", pulse_cyc.size(), 0);
      checkOutput("idle_abort_busy", busy, 0);

      $display("[TB] maximum length");
      regWrite(REG_DST_LO, 8'h23); regWrite(REG_DST_HI, 8'h01);
      regWrite(REG_LEN_LO, 8'hFF); regWrite(REG_LEN_HI, 8'hFF);
      clearLogs();
      regWrite(REG_CTRL, 8'h03); n0 = cyc;
      regWrite(REG_DST_LO, 8'h99);
      regRead(REG_DST_LO, rd_v); checkOutput("busy_dst_readback", rd_v, 8'h23);
      regRead(REG_LEN_HI, rd_v); checkOutput("len_hi_readback", rd_v, 8'h0F);
      k = 0;
      while (busy && k < 2300) begin
         idleCycles(1);
         k++;
      end
      checkOutput("full_timeout", busy, 0);
      idleCycles(2);
      checkOutput("full_writes", wr_cyc.size(), 2048);
      if (wr_adr.size() > 0) begin
         checkOutput("full_first", wr_adr[0], 'h123);
         checkOutput("full_last", wr_adr[wr_adr.size() - 1], 'h122);
      end
      checkOutput("full_pulses", pulse_cyc.size(), 1);
      if (pulse_cyc.size() > 0) checkOutput("full_pulse_cyc", pulse_cyc[0], n0 + 2049);

      $display("[TB] abort mid-run");
      regWrite(REG_DST_LO, 8'h40); regWrite(REG_DST_HI, 8'h00);
      regWrite(REG_LEN_LO, 8'h0A); regWrite(REG_LEN_HI, 8'h00);
      clearLogs();
      regWrite(REG_CTRL, 8'h03); n0 = cyc;
      idleCycles(3);
      regWrite(REG_CTRL, 8'h80);
      idleCycles(4);
      exp_off = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_adr = '{'h040, 'h041, 'h042, 'h043, 0, 0, 0, 0};
      exp_we  = '{2, 2, 2, 2, 0, 0, 0, 0};
      checkRun("abort", n0, 4, 5);
      checkOutput("abort_busy", busy, 0);

      $display("[TB] reset mid-run");
      regWrite(REG_CTRL, 8'h03);
      idleCycles(2);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_chram_we", chram_we, 0);
      checkOutput("rst_colram_we", colram_we, 0);
      repeat (2) @(posedge clk_sys);
      #1 reset_n = 1'b1;
      regRead(REG_STATUS, rd_v); checkOutput("rst_status", rd_v, 8'h00);
      regRead(REG_DST_LO, rd_v); checkOutput("rst_dst_lo", rd_v, 8'h00);
      idleCycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
